// File: rtl/nn_result_serializer.sv
// ============================================================================
//  Module   : nn_result_serializer
//  Purpose  : Snapshots the four neuron outputs on a start pulse and streams
//             them byte-serially over a valid/ready interface as
//             HEADER, neuron0..3 [, checksum].
//  Options  : NN_TX_CHECKSUM_EN - when defined, appends an XOR checksum byte
//             (HEADER ^ neuron0 ^ .. ^ neuron3) carrying tx_last.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_result_serializer #(
  parameter int               DATA_W = 8,
  parameter logic [DATA_W-1:0] HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] neuron0_output,
  input  logic [DATA_W-1:0] neuron1_output,
  input  logic [DATA_W-1:0] neuron2_output,
  input  logic [DATA_W-1:0] neuron3_output,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_snap [4];
  logic [1:0]        r_idx;
`ifdef NN_TX_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic       w_hs;
  logic [1:0] w_idx_nxt;

  // A byte moves on every edge where both sides agree
  assign w_hs      = tx_valid && tx_ready;
  assign w_idx_nxt = r_idx + 2'd1;

  // Frame sequencer: all stream outputs are registered and loaded one cycle
  // ahead, so the next byte is already on tx_data when a handshake completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
`ifdef NN_TX_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap[0] <= neuron0_output;
            r_snap[1] <= neuron1_output;
            r_snap[2] <= neuron2_output;
            r_snap[3] <= neuron3_output;
            r_idx     <= 2'd0;
            tx_data   <= HEADER;
            tx_valid  <= 1'b1;
            tx_last   <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_HDR;
`ifdef NN_TX_CHECKSUM_EN
            r_csum    <= HEADER;
`endif
          end
        end

        S_HDR: begin
          if (w_hs) begin
            tx_data <= r_snap[0];
            tx_last <= 1'b0;
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_hs) begin
`ifdef NN_TX_CHECKSUM_EN
            r_csum <= r_csum ^ tx_data;
`endif
            if (r_idx == 2'd3) begin
`ifdef NN_TX_CHECKSUM_EN
              // Checksum byte folds in the neuron3 byte accepted right now
              tx_data <= r_csum ^ tx_data;
              tx_last <= 1'b1;
              r_state <= S_CSUM;
`else
              tx_data  <= '0;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_IDLE;
`endif
            end else begin
              r_idx   <= w_idx_nxt;
              tx_data <= r_snap[w_idx_nxt];
`ifdef NN_TX_CHECKSUM_EN
              tx_last <= 1'b0;
`else
              tx_last <= (w_idx_nxt == 2'd3);
`endif
            end
          end
        end

        S_CSUM: begin
`ifdef NN_TX_CHECKSUM_EN
          if (w_hs) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end
`else
          // Unreachable without the checksum option; recover to idle
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
